// File: rtl/rgb_led_arbiter_if.sv
// rgb_led_arbiter_if
//   Groups the request, colour, grant and LED signals of the RGB LED arbiter.
//   The clock and reset are plain ports on the arbiter and are not part of
//   this interface.
//
//   Signals:
//     req[2:0]        level-held request from requesters 0..2
//     color0..2[2:0]  requested colour per requester (bit0=red, bit1=green, bit2=blue)
//     blink[2:0]      per-requester blink enable
//     gnt[2:0]        one-hot grant, or all-zero
//     busy            high while granting or in the off gap
//     LED/LED2/LED3   red/green/blue LED drive, active-low (0 = lit)
//
//   Modports:
//     master  drives requests, observes grant and LEDs (requesters / bench)
//     slave   the arbiter itself
interface rgb_led_arbiter_if;
  logic [2:0] req;
  logic [2:0] color0;
  logic [2:0] color1;
  logic [2:0] color2;
  logic [2:0] blink;
  logic [2:0] gnt;
  logic       busy;
  logic       LED;
  logic       LED2;
  logic       LED3;

  modport master (
    output req, color0, color1, color2, blink,
    input  gnt, busy, LED, LED2, LED3
  );

  modport slave (
    input  req, color0, color1, color2, blink,
    output gnt, busy, LED, LED2, LED3
  );
endinterface

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter
//   Round-robin arbiter sharing one RGB LED between three requesters. A
//   winner's colour (and blink enable) is latched on grant; the grant is held
//   for at least DWELL_CYCLES while others wait, and indefinitely when nobody
//   else asks. Between grants the LED is dark for exactly GAP_CYCLES.
//
//   Parameters:
//     DWELL_CYCLES  minimum grant hold time in CLK cycles (1..2^26-1)
//     GAP_CYCLES    LEDs-off gap between grants in CLK cycles (1..2^26-1)
//     BLINK_BIT     free-running counter bit used as blink phase (0..25)
//
//   Ports:
//     CLK   single clock, all state on its rising edge
//     RST   asynchronous, active-high reset
//     bus   rgb_led_arbiter_if.slave (req, colours, blink, gnt, busy, LEDs)
//
//   Configuration macro:
//     LED_BLINK_EN  when defined, a latched blink enable blanks the LED while
//                   counter[BLINK_BIT] is 0. When undefined, blink is ignored
//                   and the granted colour is shown steadily.
module rgb_led_arbiter #(
  parameter int unsigned DWELL_CYCLES = 12000000,
  parameter int unsigned GAP_CYCLES   = 1200000,
  parameter int unsigned BLINK_BIT    = 22
) (
  input logic             CLK,
  input logic             RST,
  rgb_led_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [25:0] DWELL_LAST = 26'(DWELL_CYCLES - 1);
  localparam logic [25:0] GAP_LAST   = 26'(GAP_CYCLES - 1);

  // Round-robin pick: first requesting index starting at (last+1) mod 3.
  // The loop walks from the farthest candidate to the nearest so that the
  // nearest requester overwrites any earlier hit.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] g;
    g = 3'b000;
    for (int k = 3; k >= 1; k--) begin
      int i;
      i = (int'(last) + k) % 3;
      if (r[i]) g = 3'(1 << i);
    end
    return g;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] w);
    if (w[1])      return 2'd1;
    else if (w[2]) return 2'd2;
    else           return 2'd0;
  endfunction

  state_e      state_q, state_d;
  logic [25:0] dwell_q, dwell_d;
  logic [25:0] gap_q,   gap_d;
  logic [25:0] cnt_q,   cnt_d;
  logic [1:0]  last_q,  last_d;
  logic [2:0]  win_q,   win_d;     // one-hot index of the current winner
  logic [2:0]  color_q, color_d;   // latched colour of the winner
  logic [2:0]  gnt_q,   gnt_d;
  logic        busy_q,  busy_d;
  logic [2:0]  led_q,   led_d;     // {blue, green, red}, active-low
`ifdef LED_BLINK_EN
  logic        blink_q, blink_d;   // latched blink enable of the winner
`else
  logic        unused_blink;
  assign unused_blink = ^bus.blink;
`endif

  logic [2:0] pick;
  logic       start_grant;
  logic       other_req;

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // through the case statement leaves a value unassigned (no latches).
    state_d     = state_q;
    dwell_d     = dwell_q;
    gap_d       = gap_q;
    last_d      = last_q;
    win_d       = win_q;
    color_d     = color_q;
`ifdef LED_BLINK_EN
    blink_d     = blink_q;
`endif
    cnt_d       = cnt_q + 26'd1;   // wraps 2^26-1 -> 0 naturally
    pick        = rr_pick(bus.req, last_q);
    start_grant = 1'b0;
    other_req   = |(bus.req & ~win_q);

    unique case (state_q)
      IDLE: begin
        start_grant = |bus.req;
      end

      GRANT: begin
        if (dwell_q != DWELL_LAST) dwell_d = dwell_q + 26'd1;
        // A dropped request and an expired dwell with a waiting competitor
        // both lead to the same release, so one branch covers both.
        if (((win_q & bus.req) == 3'b000) ||
            ((dwell_q == DWELL_LAST) && other_req)) begin
          state_d = GAP;
          gap_d   = 26'd0;
          last_d  = onehot_to_idx(win_q);
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d     = IDLE;
          start_grant = |bus.req;
        end else begin
          gap_d = gap_q + 26'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (start_grant) begin
      state_d = GRANT;
      win_d   = pick;
      dwell_d = 26'd0;
      color_d = ({3{pick[0]}} & bus.color0) |
                ({3{pick[1]}} & bus.color1) |
                ({3{pick[2]}} & bus.color2);
`ifdef LED_BLINK_EN
      blink_d = |(pick & bus.blink);
`endif
    end

    // Outputs are registered from the next-state values, so they change on
    // the same edge as the state register.
    gnt_d  = (state_d == GRANT) ? win_d : 3'b000;
    busy_d = (state_d != IDLE);
    led_d  = 3'b111;
    if (state_d == GRANT) begin
      led_d = ~color_d;
`ifdef LED_BLINK_EN
      if (blink_d && !cnt_d[BLINK_BIT]) led_d = 3'b111;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dwell_q <= 26'd0;
      gap_q   <= 26'd0;
      cnt_q   <= 26'd0;
      last_q  <= 2'd2;          // requester 0 wins the first arbitration
      win_q   <= 3'b000;
      color_q <= 3'b000;
      gnt_q   <= 3'b000;
      busy_q  <= 1'b0;
      led_q   <= 3'b111;
`ifdef LED_BLINK_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      color_q <= color_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
`ifdef LED_BLINK_EN
      blink_q <= blink_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.LED  = led_q[0];
  assign bus.LED2 = led_q[1];
  assign bus.LED3 = led_q[2];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter
//   Self-checking bench for rgb_led_arbiter with DWELL_CYCLES=8,
//   GAP_CYCLES=2, BLINK_BIT=2. A table of single-cycle vectors covers basic
//   grant, colour latching, drop-to-gap and round-robin re-grant; hand-written
//   sequences cover full dwell rotation, reset mid-grant, dwell saturation and
//   blink phase.
module tb_rgb_led_arbiter;

  logic CLK;
  logic RST;

  rgb_led_arbiter_if bus ();

  rgb_led_arbiter #(
    .DWELL_CYCLES(8),
    .GAP_CYCLES  (2),
    .BLINK_BIT   (2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_run  = 0;
  int n_fail = 0;

  // Expected LEDs are packed {LED3, LED2, LED}.
  typedef struct {
    logic [2:0] req;
    logic [2:0] c0;
    logic [2:0] c1;
    logic [2:0] c2;
    logic [2:0] blink;
    logic [2:0] exp_gnt;
    logic       exp_busy;
    logic [2:0] exp_led;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [2:0] g,
                            input logic b, input logic [2:0] l);
    check({name, ".gnt"},  {1'b0, bus.gnt}, {1'b0, g});
    check({name, ".busy"}, {3'b000, bus.busy}, {3'b000, b});
    check({name, ".led"},  {1'b0, bus.LED3, bus.LED2, bus.LED}, {1'b0, l});
  endtask

  // Pulse reset for one edge, then release 1 time unit after an edge.
  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic set_in(input logic [2:0] r, input logic [2:0] c0, input logic [2:0] c1,
                        input logic [2:0] c2, input logic [2:0] bl);
    bus.req    = r;
    bus.color0 = c0;
    bus.color1 = c1;
    bus.color2 = c2;
    bus.blink  = bl;
  endtask

  initial begin
    logic [2:0] colors [3];
    logic [2:0] exp_led;
    colors[0] = 3'b001;
    colors[1] = 3'b010;
    colors[2] = 3'b100;

    //            req     c0      c1      c2      blink   gnt     busy  led
    vecs[0]  = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 1'b1, 3'b110};
    vecs[1]  = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 1'b1, 3'b110};
    vecs[2]  = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b000, 3'b001, 1'b1, 3'b110};
    vecs[3]  = '{3'b000, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b1, 3'b111};
    vecs[4]  = '{3'b000, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b1, 3'b111};
    vecs[5]  = '{3'b000, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b0, 3'b111};
    vecs[6]  = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b000, 3'b001, 1'b1, 3'b011};
    vecs[7]  = '{3'b011, 3'b100, 3'b010, 3'b100, 3'b000, 3'b001, 1'b1, 3'b011};
    vecs[8]  = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b1, 3'b111};
    vecs[9]  = '{3'b011, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b1, 3'b111};
    vecs[10] = '{3'b011, 3'b100, 3'b010, 3'b100, 3'b000, 3'b010, 1'b1, 3'b101};
    vecs[11] = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b1, 3'b111};
    vecs[12] = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b1, 3'b111};
    vecs[13] = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b000, 3'b001, 1'b1, 3'b011};
    vecs[14] = '{3'b000, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b1, 3'b111};
    vecs[15] = '{3'b000, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b1, 3'b111};
    vecs[16] = '{3'b000, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000, 1'b0, 3'b111};

    // Reset state.
    RST = 1'b1;
    set_in(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    step();
    step();
    check_outs("reset", 3'b000, 1'b0, 3'b111);
    RST = 1'b0;

    // Table: grant, colour latch, drop to gap, idle, round-robin re-grant.
    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].req, vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].blink);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_busy, vecs[i].exp_led);
    end

    // Full rotation 0,1,2,0 with 8-cycle grants and 2-cycle gaps.
    set_in(3'b111, colors[0], colors[1], colors[2], 3'b000);
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        check_outs($sformatf("rot%0d_g%0d", r, c), 3'(1 << (r % 3)), 1'b1, ~colors[r % 3]);
      end
      for (int c = 0; c < 2; c++) begin
        step();
        check_outs($sformatf("rot%0d_gap%0d", r, c), 3'b000, 1'b1, 3'b111);
      end
    end

    // After the fourth grant (0) requester 1 is next; reset it mid-grant.
    step();
    check_outs("rst_pre", 3'b010, 1'b1, 3'b101);
    step();
    RST = 1'b1;
    #1;
    check_outs("rst_async", 3'b000, 1'b0, 3'b111);
    step();
    RST = 1'b0;
    step();
    check_outs("rst_first", 3'b001, 1'b1, 3'b110);

    // Lone requester holds past the dwell; a competitor then forces release.
    set_in(3'b001, colors[0], colors[1], colors[2], 3'b000);
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step();
      check({"hold", $sformatf("%0d", c)}, {1'b0, bus.gnt}, 4'b0001);
    end
    bus.req = 3'b011;
    step();
    check_outs("sat_release", 3'b000, 1'b1, 3'b111);
    step();
    step();
    check_outs("sat_next", 3'b010, 1'b1, 3'b101);

    // Blink phase on requester 1 with colour green+blue.
    set_in(3'b010, 3'b001, 3'b110, 3'b100, 3'b010);
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
`ifdef LED_BLINK_EN
      exp_led = (((k >> 2) & 1) != 0) ? 3'b001 : 3'b111;
`else
      exp_led = 3'b001;
`endif
      check_outs($sformatf("blink%0d", k), 3'b010, 1'b1, exp_led);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
RGB_LED_ARBITER -- requirements
Module: rgb_led_arbiter

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 12000000, giving the minimum grant hold time in CLK cycles (1 s at 12 MHz); legal range 1..2^26-1.
REQ-002 SHALL have parameter GAP_CYCLES, default 1200000, giving the LEDs-off gap between grants in CLK cycles; legal range 1..2^26-1.
REQ-003 SHALL have parameter BLINK_BIT, default 22, selecting the free-running counter bit used as blink phase; legal range 0..25.
REQ-004 CLK  input  1  single clock; all state on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 req  input  3  request from requesters 0..2, level-held while wanted.
REQ-007 color0/color1/color2  input  3 each  requested colour, bit0=red, bit1=green, bit2=blue.
REQ-008 blink  input  3  per-requester blink enable.
REQ-009 gnt  output  3  one-hot grant, or all-zero.
REQ-010 busy  output  1  high in GRANT or GAP.
REQ-011 LED/LED2/LED3  output  1 each  red/green/blue drive, active-low (0 = lit).

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-013 IDLE: gnt=0, all LEDs=1; when any req bit is 1, SHALL enter GRANT next cycle, granting the first requesting index found round-robin starting at (last_grant+1) mod 3.
REQ-014 On entry to GRANT, SHALL latch the winner's colour and blink bit; later changes to colorN/blink during the grant SHALL be ignored.
REQ-015 GRANT: gnt one-hot for the winner; LED/LED2/LED3 = ~latched colour bits, forced to 1 when latched blink=1 and counter[BLINK_BIT]=0.
REQ-016 A 26-bit dwell counter SHALL load 0 on GRANT entry and increment each GRANT cycle, saturating at DWELL_CYCLES-1.
REQ-017 GRANT exit to GAP SHALL occur when the granted req bit is 0, or when the dwell counter equals DWELL_CYCLES-1 and another req bit is 1; otherwise the grant SHALL hold indefinitely.
REQ-018 If the granted req drops in the same cycle the dwell expires, SHALL take the drop path to GAP (identical result).
REQ-019 GAP: gnt=0, all LEDs=1, lasting exactly GAP_CYCLES cycles, then IDLE arbitration rules apply (GRANT if any req, else IDLE); last_grant SHALL be updated to the just-released index.
REQ-020 gnt SHALL never have more than one bit set; LEDs SHALL be driven only from the latched grant colour.
REQ-021 A 26-bit free-running counter SHALL increment every CLK cycle, wrapping 2^26-1 -> 0 without affecting FSM state.
REQ-022 Outputs SHALL be registered; LED changes lag the FSM state change by at most 1 cycle.

Reset
REQ-023 RST=1 SHALL immediately force state=IDLE, gnt=0, busy=0, LED=LED2=LED3=1, dwell, gap and free-running counters=0, last_grant=2 (so requester 0 wins first).
REQ-024 Reset asserted mid-GRANT or mid-GAP SHALL abandon the operation without a GAP period; arbitration restarts on the first CLK edge after RST falls.

Configuration
REQ-025 Macro LED_BLINK_EN: when defined, blink behaviour per REQ-015 is compiled in.
REQ-026 Without LED_BLINK_EN, the blink input SHALL be ignored, the latched blink bit SHALL be omitted, and the granted colour SHALL be shown steadily; the free-running counter SHALL still exist.

Verification (DWELL_CYCLES=8, GAP_CYCLES=2, BLINK_BIT=2)
REQ-027 Release RST, req=001, color0=001, blink=0 -> after 1 cycle gnt=001, busy=1, LED=0, LED2=1, LED3=1, held steadily while req0 holds.
REQ-028 req=111 from reset -> grant order 0,1,2,0 with each grant exactly 8 cycles, followed by 2 cycles of gnt=0 and all LEDs=1.
REQ-029 req0 granted, drop req0 on cycle 3 -> GAP for 2 cycles, then IDLE (gnt=0, busy=0); if req0 is still requested, it is re-granted after the gap.
REQ-030 LED_BLINK_EN defined, color1=110, blink=010, req=010 -> LED2/LED3 toggle with a period of 8 cycles (4 lit, 4 dark) and LED stays 1; with the macro undefined, LED2=LED3=0 steadily.
REQ-031 RST pulsed during GRANT of requester 1 -> same cycle gnt=0 and LEDs=111; after release with req=111, requester 0 is granted first.
REQ-032 Change color0 mid-grant -> LEDs unchanged until the next grant of requester 0.
